column_parity_top: RTL and testbench
====================================

Name: column_parity_top

Overview:
- Theta (column-parity) stage of the matrix encoder. It sits directly upstream of rotate_top.
- Reads a 64-slice x 25-bit state from the slice memory one slice per access.
- XORs each bit with the parities of two neighbouring columns.
- Emits one write pulse per slice, in the same line format rotate_top consumes.

Parameters:
- LINE_W, 25: bits per slice line. Fixed 5x5; bit index = 5*y + x, with x, y in 0..4.
- DEPTH, 64: slices per state (lane length).
- ADDR_W, 6: width of the slice address; log2(DEPTH).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset. rst=0 clears all state immediately.
- parity_en, input, 1: start request, level-sampled in IDLE.
- cnt_value, output, ADDR_W: slice read address. The memory returns line_in combinationally in the same cycle.
- line_in, input, LINE_W: slice data at cnt_value.
- write_enable, output, 1: one-cycle pulse per result slice.
- write_addr, output, ADDR_W: slice index of write_value.
- write_value, output, LINE_W: theta result slice.
- donee, output, 1: pass complete.

Behaviour:
- Column parity of slice z: C_z[x] = XOR over y of line(z)[5y+x].
- Per-column term: D_z[x] = C_z[(x+4)%5] ^ C_(z-1)[(x+1)%5]. z-1 wraps, so slice 0 uses C_63.
- Output bit: out(z)[5y+x] = line(z)[5y+x] ^ D_z[x].
- Reset values: state=IDLE, cnt_value=0, write_enable=0, write_addr=0, write_value=0, donee=0, prev_par (5-bit) = 0.
- FSM states: IDLE, LOAD_LAST, READ, WRITE, FINISH.
- IDLE: cnt_value=0. If parity_en=1 at an edge, go to LOAD_LAST with cnt_value<=DEPTH-1.
- LOAD_LAST: prev_par<=C(line_in), which is slice 63. Then cnt_value<=0 and go to READ.
- READ: compute out from line_in and prev_par. At the edge:
  - write_value<=out, write_addr<=cnt_value, write_enable<=1;
  - prev_par<=C(line_in);
  - go to WRITE.
- WRITE: write_enable=1 for exactly this cycle. At the edge, write_enable<=0, then:
  - if cnt_value==DEPTH-1: donee<=1, go to FINISH;
  - else cnt_value<=cnt_value+1, go to READ.
- write_enable therefore returns low between every write, giving 64 distinct rising edges.
- FINISH: donee held high while parity_en=1. When parity_en=0 at an edge: donee<=0, cnt_value<=0, go to IDLE.
  - If parity_en is already 0 on entry, donee is high for exactly one cycle.
- Latency, with parity_en sampled at edge E0:
  - first write_enable high after E2;
  - k-th write (k=0..63) high after edge E(2+2k);
  - donee high after E129.
- write_value and write_addr hold their last value outside WRITE.
- cnt_value never exceeds DEPTH-1. The increment wraps only via the explicit IDLE clear.
- parity_en deasserted mid-pass is ignored; the pass completes.
- parity_en held high after FINISH→IDLE does not restart until it has been seen low.
- Reset mid-pass (rst=0) aborts immediately to reset values. A write in flight is dropped; no partial write pulse after reset release.
- line_in is only sampled in LOAD_LAST and READ.

Test Plan:
- All-zero memory, parity_en=1 -> 64 write pulses, addresses 0..63 in order, every write_value=0, donee after 129 edges.
- Single bit at slice 0, bit 0 -> slice 0 = 25'h0210843, slice 1 = 25'h1084210, all other slices 0.
- Single bit at slice 63, bit 0 (wrap) -> slice 63 = 25'h0210843, slice 0 = 25'h1084210, all others 0.
- Slice 5 = bits 0 and 5 (even column parity), rest 0 -> slice 5 output unchanged (25'h0000021), all others 0.
- All-ones memory -> every output slice = 25'h1FFFFFF, since D=0 everywhere.
- rst=0 pulsed after 20th write, then parity_en re-asserted -> outputs at reset values immediately; a full new 64-write pass follows; donee sampled once per pass; holding parity_en high after donee gives no second pass until it is dropped.

Source files
------------

// File: rtl/column_parity_top.sv
// Theta (column-parity) stage of the matrix encoder, feeding rotate_top.
// One pass reads all DEPTH slices (after a priming read of the last slice),
// XORs every bit with the parities of two neighbouring columns, and writes
// each result slice back with a one-cycle write pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   parity_en    start request, level-sampled in idle
//   cnt_value    slice read address; line_in must be valid in the same cycle
//   line_in      slice data at cnt_value
//   write_enable one-cycle pulse per result slice
//   write_addr   slice index of write_value
//   write_value  theta result slice
//   donee        pass complete, held while parity_en stays high
module column_parity_top #(
  parameter int unsigned LINE_W = 25,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parity_en,
  output logic [ADDR_W-1:0] cnt_value,
  input  logic [LINE_W-1:0] line_in,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [LINE_W-1:0] write_value,
  output logic              donee
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadLast,
    StRead,
    StWrite,
    StFinish
  } state_e;

  localparam logic [ADDR_W-1:0] LastSlice = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] val_q, val_d;
  logic              done_q, done_d;
  logic [4:0]        prev_par_q, prev_par_d;

  logic [4:0]        cur_par;
  logic [4:0]        col_term;
  logic [LINE_W-1:0] theta_out;

  // Column parity of the current slice, then the per-column term mixing
  // column x-1 of this slice with column x+1 of the previous slice.
  always_comb begin
    cur_par   = '0;
    col_term  = '0;
    theta_out = line_in;
    for (int x = 0; x < 5; x++) begin
      cur_par[x] = line_in[x] ^ line_in[5 + x] ^ line_in[10 + x] ^
                   line_in[15 + x] ^ line_in[20 + x];
    end
    for (int x = 0; x < 5; x++) begin
      col_term[x] = cur_par[(x + 4) % 5] ^ prev_par_q[(x + 1) % 5];
    end
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        theta_out[5 * y + x] = line_in[5 * y + x] ^ col_term[x];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    val_d      = val_q;
    done_d     = done_q;
    prev_par_d = prev_par_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (parity_en) begin
          cnt_d   = LastSlice;
          state_d = StLoadLast;
        end
      end
      StLoadLast: begin
        // Slice 0 needs the parity of the last slice as its "previous".
        prev_par_d = cur_par;
        cnt_d      = '0;
        state_d    = StRead;
      end
      StRead: begin
        val_d      = theta_out;
        addr_d     = cnt_q;
        we_d       = 1'b1;
        prev_par_d = cur_par;
        state_d    = StWrite;
      end
      StWrite: begin
        if (cnt_q == LastSlice) begin
          done_d  = 1'b1;
          state_d = StFinish;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = StRead;
        end
      end
      StFinish: begin
        // Waiting for parity_en to drop prevents an immediate restart.
        if (!parity_en) begin
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      val_q      <= '0;
      done_q     <= 1'b0;
      prev_par_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      val_q      <= val_d;
      done_q     <= done_d;
      prev_par_q <= prev_par_d;
    end
  end

  assign cnt_value    = cnt_q;
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_value  = val_q;
  assign donee        = done_q;

endmodule

// File: tb/tb_column_parity_top.sv
// Self-checking bench for column_parity_top: a slice memory model drives
// line_in, and each pass is compared against a whole-state theta reference.
module tb_column_parity_top;

  logic        clk;
  logic        rst;
  logic        parity_en;
  logic [5:0]  cnt_value;
  logic [24:0] line_in;
  logic        write_enable;
  logic [5:0]  write_addr;
  logic [24:0] write_value;
  logic        donee;

  logic [24:0] mem     [64];
  logic [24:0] exp_mem [64];
  logic [4:0]  col     [64];

  int checks = 0;
  int errors = 0;

  column_parity_top #(
    .LINE_W(25),
    .DEPTH (64),
    .ADDR_W(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .parity_en   (parity_en),
    .cnt_value   (cnt_value),
    .line_in     (line_in),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_value (write_value),
    .donee       (donee)
  );

  assign line_in = mem[cnt_value];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference theta over the whole state, straight from the column rules.
  function automatic void compute_expected();
    for (int z = 0; z < 64; z++) begin
      for (int x = 0; x < 5; x++) begin
        col[z][x] = 1'b0;
        for (int y = 0; y < 5; y++) col[z][x] = col[z][x] ^ mem[z][5 * y + x];
      end
    end
    for (int z = 0; z < 64; z++) begin
      for (int x = 0; x < 5; x++) begin
        logic d;
        d = col[z][(x + 4) % 5] ^ col[(z + 63) % 64][(x + 1) % 5];
        for (int y = 0; y < 5; y++) exp_mem[z][5 * y + x] = mem[z][5 * y + x] ^ d;
      end
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, write_enable, 0);
    check({tag, "_waddr"}, write_addr, 0);
    check({tag, "_wval"}, write_value, 0);
    check({tag, "_donee"}, donee, 0);
    check({tag, "_cnt"}, cnt_value, 0);
  endtask

  // Runs one pass; cycle index cyc is the edge number counted from the edge
  // that samples parity_en. stop_after < 64 aborts via reset after that write.
  task automatic do_pass(input int stop_after, input bit hold_en);
    int k;
    bit aborted;
    k = 0;
    aborted = 0;
    compute_expected();
    @(negedge clk);
    parity_en = 1'b1;
    for (int cyc = 0; cyc <= 129 && !aborted; cyc++) begin
      @(posedge clk);
      #1;
      if (!hold_en && cyc == 3) parity_en = 1'b0;  // mid-pass drop is ignored
      if (write_enable) begin
        check("write_time", cyc, 2 + 2 * k);
        check("write_addr", write_addr, k);
        if (k < 64) check("write_value", write_value, exp_mem[k]);
        k++;
        if (k == stop_after) aborted = 1;
      end
      if (cyc == 128) check("donee_early", donee, 0);
      if (cyc == 129) check("donee_rise", donee, 1);
    end
    if (aborted) begin
      rst = 1'b0;
      #1;
      check_reset_outputs("abort");
      parity_en = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        check("abort_no_we", write_enable, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      return;
    end
    check("write_count", k, 64);
    if (hold_en) begin
      repeat (8) begin
        @(posedge clk);
        #1;
        check("hold_no_restart", write_enable, 0);
      end
      check("hold_donee", donee, 1);
      parity_en = 1'b0;
      @(posedge clk);
      #1;
      check("hold_release_donee", donee, 0);
      check("hold_release_cnt", cnt_value, 0);
    end else begin
      @(posedge clk);
      #1;
      check("donee_pulse_end", donee, 0);
      check("idle_cnt", cnt_value, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    parity_en = 1'b0;
    for (int z = 0; z < 64; z++) mem[z] = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // All-zero memory.
    do_pass(64, 1'b0);

    // Single bit in slice 0.
    mem[0] = 25'h1;
    do_pass(64, 1'b0);

    // Single bit in slice 63 exercises the wrap into slice 0.
    mem[0]  = '0;
    mem[63] = 25'h1;
    do_pass(64, 1'b0);

    // Even column parity in slice 5 leaves everything unchanged.
    mem[63] = '0;
    mem[5]  = 25'h21;
    do_pass(64, 1'b0);

    // All ones: every column parity is 1, so every term cancels.
    for (int z = 0; z < 64; z++) mem[z] = 25'h1FFFFFF;
    do_pass(64, 1'b0);

    // Dense random states.
    repeat (2) begin
      for (int z = 0; z < 64; z++) mem[z] = 25'($urandom());
      do_pass(64, 1'b0);
    end

    // Sparse random state.
    for (int z = 0; z < 64; z++) mem[z] = '0;
    repeat (6) begin
      int zz;
      int bb;
      zz = $urandom_range(63, 0);
      bb = $urandom_range(24, 0);
      mem[zz][bb] = 1'b1;
    end
    do_pass(64, 1'b0);

    // Reset after the 20th write, then a full pass with parity_en held high.
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom());
    do_pass(20, 1'b0);
    do_pass(64, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
